// File: rtl/pwm_capture.sv
// pwm_capture: measures the high time and period of PwmIn in clock cycles and
// exposes HIGH / PERIOD / STATUS as read-only registers with a registered read port.
module pwm_capture #(
  parameter int WIDTH = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        CS_N,
  input  logic        RD_N,
  input  logic [11:0] Addr,
  input  logic        PwmIn,
  output logic [31:0] DataOut
);

  localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [11:0]      ADDR_HIGH   = 12'h100;
  localparam logic [11:0]      ADDR_PERIOD = 12'h104;
  localparam logic [11:0]      ADDR_STATUS = 12'h108;

  typedef enum logic [1:0] {
    WAIT_RISE1 = 2'd0,
    WAIT_FALL  = 2'd1,
    WAIT_RISE2 = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic             sync1_r, sync2_r, sync3_r;
  logic             rise_s, fall_s;
  logic [WIDTH-1:0] cnt_r, cnt_s;
  logic [WIDTH-1:0] cnt_inc_s;
  logic [WIDTH-1:0] high_tmp_r, high_tmp_s;
  logic [WIDTH-1:0] high_r, high_s;
  logic [WIDTH-1:0] period_r, period_s;
  logic             valid_r, valid_s;
  logic             ovf_r, ovf_s;
  logic             capture_s, timeout_s;
  logic             rd_s, status_rd_s;
  logic [31:0]      rdata_s;

  // Two-flop synchronizer plus one delay stage for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      sync3_r <= 1'b0;
    end else begin
      sync1_r <= PwmIn;
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
    end
  end

  assign rise_s    = sync2_r & ~sync3_r;
  assign fall_s    = ~sync2_r & sync3_r;
  // Saturating increment: the counter parks at CNT_MAX so the timeout always fires.
  assign cnt_inc_s = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_ONE;

  // Measurement FSM next-state, counter and capture logic.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    high_tmp_s = high_tmp_r;
    high_s     = high_r;
    period_s   = period_r;
    capture_s  = 1'b0;
    timeout_s  = 1'b0;
    case (state_r)
      WAIT_RISE1: begin
        if (rise_s) begin
          cnt_s   = CNT_ONE;
          state_s = WAIT_FALL;
        end else begin
          cnt_s = cnt_r;
        end
      end
      WAIT_FALL: begin
        if (fall_s) begin
          high_tmp_s = cnt_r;
          cnt_s      = cnt_inc_s;
          state_s    = WAIT_RISE2;
        end else if (cnt_r == CNT_MAX) begin
          timeout_s = 1'b1;
          state_s   = WAIT_RISE1;
        end else begin
          cnt_s = cnt_inc_s;
        end
      end
      WAIT_RISE2: begin
        if (rise_s) begin
          period_s  = cnt_r;
          high_s    = high_tmp_r;
          capture_s = 1'b1;
          cnt_s     = CNT_ONE;
          state_s   = WAIT_FALL;
        end else if (cnt_r == CNT_MAX) begin
          timeout_s = 1'b1;
          state_s   = WAIT_RISE1;
        end else begin
          cnt_s = cnt_inc_s;
        end
      end
      default: begin
        state_s = WAIT_RISE1;
      end
    endcase
  end

  assign rd_s        = ~CS_N & ~RD_N;
  assign status_rd_s = rd_s & (Addr == ADDR_STATUS);

  // Sticky flags: a new capture/timeout in the read cycle wins over the clear.
  always_comb begin
    if (capture_s) begin
      valid_s = 1'b1;
    end else if (status_rd_s) begin
      valid_s = 1'b0;
    end else begin
      valid_s = valid_r;
    end
    if (timeout_s) begin
      ovf_s = 1'b1;
    end else if (status_rd_s) begin
      ovf_s = 1'b0;
    end else begin
      ovf_s = ovf_r;
    end
  end

  // Read mux; assumes WIDTH < 32 for the zero extension.
  always_comb begin
    rdata_s = 32'd0;
    if (rd_s) begin
      case (Addr)
        ADDR_HIGH:   rdata_s = {{(32-WIDTH){1'b0}}, high_r};
        ADDR_PERIOD: rdata_s = {{(32-WIDTH){1'b0}}, period_r};
        ADDR_STATUS: rdata_s = {30'd0, ovf_r, valid_r};
        default:     rdata_s = 32'd0;
      endcase
    end else begin
      rdata_s = 32'd0;
    end
  end

  // State, measurement registers and read data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= WAIT_RISE1;
      cnt_r      <= {WIDTH{1'b0}};
      high_tmp_r <= {WIDTH{1'b0}};
      high_r     <= {WIDTH{1'b0}};
      period_r   <= {WIDTH{1'b0}};
      valid_r    <= 1'b0;
      ovf_r      <= 1'b0;
      DataOut    <= 32'd0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      high_tmp_r <= high_tmp_s;
      high_r     <= high_s;
      period_r   <= period_s;
      valid_r    <= valid_s;
      ovf_r      <= ovf_s;
      DataOut    <= rdata_s;
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Randomized scoreboard bench for pwm_capture: a timestamp-based reference model
// predicts every DataOut value; a monitor compares one cycle after each request.
module tb_pwm_capture;

  localparam int W    = 12;
  localparam int MAXC = (1 << W) - 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        CS_N;
  logic        RD_N;
  logic [11:0] Addr;
  logic        PwmIn;
  logic [31:0] DataOut;

  pwm_capture #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .CS_N    (CS_N),
    .RD_N    (RD_N),
    .Addr    (Addr),
    .PwmIn   (PwmIn),
    .DataOut (DataOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] val;
    logic [11:0] addr;
    logic        rd;
  } exp_t;

  exp_t expq[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: edges are time-stamped in clock edges since reset release.
  int   hist[$];
  int   mode;      // 0 unarmed, 1 high phase after a rise, 2 low phase after a fall
  int   rise_t;
  int   htmp;
  int   m_high;
  int   m_period;
  bit   m_valid;
  bit   m_ovf;
  logic pwm_lvl;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", name, got, want);
    end
  endtask

  function automatic int hv(input int i);
    return (i < 0) ? 0 : hist[i];
  endfunction

  function automatic logic [31:0] model_read(input logic [11:0] a);
    case (a)
      12'h100: return 32'(m_high);
      12'h104: return 32'(m_period);
      12'h108: return {30'd0, m_ovf, m_valid};
      default: return 32'd0;
    endcase
  endfunction

  function automatic void model_reset();
    hist.delete();
    mode     = 0;
    rise_t   = 0;
    htmp     = 0;
    m_high   = 0;
    m_period = 0;
    m_valid  = 1'b0;
    m_ovf    = 1'b0;
  endfunction

  // An input edge sampled at edge k takes effect at edge k+2.
  function automatic void model_edge(input logic pwm, input bit st_rd);
    int e;
    bit rise, fall, cap, tmo;
    hist.push_back(int'(pwm));
    e    = hist.size() - 1;
    rise = (hv(e-2) == 1) && (hv(e-3) == 0);
    fall = (hv(e-2) == 0) && (hv(e-3) == 1);
    cap  = 1'b0;
    tmo  = 1'b0;
    if (mode == 0) begin
      if (rise) begin rise_t = e; mode = 1; end
    end else if (mode == 1) begin
      if (fall) begin htmp = e - rise_t; mode = 2; end
      else if (e - rise_t >= MAXC) begin tmo = 1'b1; mode = 0; end
    end else begin
      if (rise) begin
        m_period = e - rise_t; m_high = htmp; cap = 1'b1; rise_t = e; mode = 1;
      end else if (e - rise_t >= MAXC) begin
        tmo = 1'b1; mode = 0;
      end
    end
    if (st_rd && !cap) m_valid = 1'b0;
    if (st_rd && !tmo) m_ovf = 1'b0;
    if (cap) m_valid = 1'b1;
    if (tmo) m_ovf = 1'b1;
  endfunction

  function automatic logic [11:0] pick_addr();
    case ($urandom_range(5))
      0: return 12'h100;
      1: return 12'h104;
      2: return 12'h108;
      3: return 12'h000;
      4: return 12'h10C;
      default: return 12'($urandom);
    endcase
  endfunction

  // One clock: drive inputs after a falling edge, push the expected DataOut.
  task automatic step(input logic rd, input logic [11:0] a);
    exp_t x;
    int   r;
    PwmIn = pwm_lvl;
    Addr  = a;
    if (rd) begin
      CS_N = 1'b0; RD_N = 1'b0;
    end else begin
      r = $urandom_range(2);
      CS_N = (r != 2);
      RD_N = (r != 1);
    end
    x.val  = rd ? model_read(a) : 32'd0;
    x.addr = a;
    x.rd   = rd;
    expq.push_back(x);
    model_edge(pwm_lvl, rd && (a == 12'h108));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rd(input logic [11:0] a);
    step(1'b1, a);
  endtask

  task automatic hold(input int n, input int pct);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(99) < pct) step(1'b1, pick_addr());
      else step(1'b0, 12'($urandom));
    end
  endtask

  task automatic wave(input int h, input int l, input int pct);
    pwm_lvl = 1'b1; hold(h, pct);
    pwm_lvl = 1'b0; hold(l, pct);
  endtask

  // Monitor: DataOut is checked shortly after every edge that had a request queued.
  initial begin
    exp_t mx;
    forever begin
      @(posedge clk);
      #2;
      if (expq.size() > 0) begin
        mx = expq.pop_front();
        if (mx.rd) chk($sformatf("read_%h", mx.addr), DataOut, mx.val);
        else       chk("idle_zero", DataOut, mx.val);
      end
    end
  end

  initial begin
    reset   = 1'b1;
    CS_N    = 1'b1;
    RD_N    = 1'b1;
    Addr    = 12'h000;
    PwmIn   = 1'b0;
    pwm_lvl = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_dataout", DataOut, 32'd0);
    reset = 1'b0;
    model_reset();

    rd(12'h108);
    rd(12'h100);
    rd(12'h104);

    // 25 high / 100 period, then read all registers twice for STATUS clear.
    for (int i = 0; i < 3; i++) wave(25, 75, 0);
    pwm_lvl = 1'b1; hold(25, 0);
    pwm_lvl = 1'b0; hold(71, 0);
    rd(12'h100); rd(12'h104); rd(12'h108); rd(12'h108);

    // Switch to 1 high / 2 period with frequent reads.
    for (int i = 0; i < 6; i++) wave(1, 1, 40);
    rd(12'h100); rd(12'h104);

    // STATUS read every cycle while captures complete every other cycle.
    for (int i = 0; i < 12; i++) begin
      pwm_lvl = (i % 2 == 0);
      rd(12'h108);
    end
    pwm_lvl = 1'b0;
    hold(4, 0);
    rd(12'h108);
    rd(12'h108);

    // 100% duty timeout, then recovery.
    wave(30, 70, 0);
    wave(30, 70, 0);
    pwm_lvl = 1'b1;
    hold(MAXC + 5, 1);
    rd(12'h108); rd(12'h100); rd(12'h104); rd(12'h108);
    for (int i = 0; i < 3; i++) wave(10, 20, 10);
    rd(12'h100); rd(12'h104); rd(12'h108);

    // 0% duty timeout while waiting for the second rise.
    pwm_lvl = 1'b0;
    hold(MAXC + 5, 1);
    rd(12'h108); rd(12'h100); rd(12'h104);

    // Randomized pulse trains with random reads.
    for (int i = 0; i < 40; i++) wave($urandom_range(60, 1), $urandom_range(60, 1), 20);

    // Reset in the middle of a high phase.
    wave(12, 12, 0);
    wave(12, 12, 0);
    pwm_lvl = 1'b1;
    hold(6, 0);
    rd(12'h100);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_dataout", DataOut, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    hold(20, 0);
    pwm_lvl = 1'b0;
    hold(20, 0);
    rd(12'h108); rd(12'h100); rd(12'h104);
    for (int i = 0; i < 2; i++) wave(5, 5, 0);
    rd(12'h100); rd(12'h104); rd(12'h108);

    // Unmapped addresses and idle cycles.
    rd(12'h000);
    rd(12'h10C);
    rd(12'hFFF);
    hold(3, 0);

    @(posedge clk);
    #3;
    chk("queue_drained", 32'(expq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
